// File: rtl/jtag_tap_param_pkg.sv
// Shared TAP definitions: state codes, DR selection, opcode helpers.
// Imported by the TAP controller FSM and the TAP top.
package jtag_tap_param_pkg;

   typedef enum logic [3:0] {
      TLR   = 4'hF,
      RTI   = 4'hC,
      SELDR = 4'h7,
      CAPDR = 4'h6,
      SHDR  = 4'h2,
      EX1DR = 4'h1,
      PDR   = 4'h3,
      EX2DR = 4'h0,
      UPDR  = 4'h5,
      SELIR = 4'h4,
      CAPIR = 4'hE,
      SHIR  = 4'hA,
      EX1IR = 4'h9,
      PIR   = 4'hB,
      EX2IR = 4'h8,
      UPIR  = 4'hD
   } tap_state_e;

   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_USERCODE,
      DR_BSR
   } dr_sel_e;

   localparam int OP_SAMPLE   = 1;
   localparam int OP_EXTEST   = 2;
   localparam int OP_INTEST   = 3;
   localparam int OP_IDCODE   = 7;
   localparam int OP_USERCODE = 8;

   // BYPASS is the all-ones opcode for any IR width
   function automatic int bypass_op(input int w);
      return (1 << w) - 1;
   endfunction

   function automatic logic idcode_ok(input logic [31:0] v);
      return v[0];
   endfunction

endpackage

// File: rtl/jtag_tap_param_if.sv
// TAP pin and core-side bundle; TCK/TRST stay plain ports.
// master drives pins/capture inputs, slave is the TAP itself.
interface jtag_tap_param_if #(
   parameter int IR_WIDTH = 4,
   parameter int BSR_LEN  = 10
);
   logic                TMS;
   logic                TDI;
   logic                TDO;
   logic                TDO_EN;
   logic [3:0]          state;
   logic [IR_WIDTH-1:0] ir_latched;
   logic                sel_idcode;
   logic                sel_bypass;
   logic                sel_sample;
   logic                sel_extest;
   logic                sel_intest;
   logic                sel_usercode;
   logic [BSR_LEN-1:0]  bsr_pin_in;
   logic [BSR_LEN-1:0]  bsr_update;

   modport master (
      output TMS, TDI, bsr_pin_in,
      input  TDO, TDO_EN, state, ir_latched,
      input  sel_idcode, sel_bypass, sel_sample,
      input  sel_extest, sel_intest, sel_usercode,
      input  bsr_update
   );

   modport slave (
      input  TMS, TDI, bsr_pin_in,
      output TDO, TDO_EN, state, ir_latched,
      output sel_idcode, sel_bypass, sel_sample,
      output sel_extest, sel_intest, sel_usercode,
      output bsr_update
   );

endinterface

// File: rtl/jtag_tap_param_tap_fsm.sv
// 16-state 1149.1 TAP controller with per-state action strobes.
// Strobes reflect the current state, i.e. the action of the next TCK edge.
module tap_fsm
   import jtag_tap_param_pkg::*;
(
   input  logic       TCK,
   input  logic       TRST,
   input  logic       TMS,
   output tap_state_e state,
   output logic       tlr,
   output logic       cap_dr,
   output logic       sh_dr,
   output logic       upd_dr,
   output logic       cap_ir,
   output logic       sh_ir,
   output logic       upd_ir
);

   tap_state_e state_q;
   tap_state_e state_d;

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) state_q <= TLR;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:   state_d = TMS ? TLR   : RTI;
         RTI:   state_d = TMS ? SELDR : RTI;
         SELDR: state_d = TMS ? SELIR : CAPDR;
         CAPDR: state_d = TMS ? EX1DR : SHDR;
         SHDR:  state_d = TMS ? EX1DR : SHDR;
         EX1DR: state_d = TMS ? UPDR  : PDR;
         PDR:   state_d = TMS ? EX2DR : PDR;
         EX2DR: state_d = TMS ? UPDR  : SHDR;
         UPDR:  state_d = TMS ? SELDR : RTI;
         SELIR: state_d = TMS ? TLR   : CAPIR;
         CAPIR: state_d = TMS ? EX1IR : SHIR;
         SHIR:  state_d = TMS ? EX1IR : SHIR;
         EX1IR: state_d = TMS ? UPIR  : PIR;
         PIR:   state_d = TMS ? EX2IR : PIR;
         EX2IR: state_d = TMS ? UPIR  : SHIR;
         UPIR:  state_d = TMS ? SELDR : RTI;
      endcase
   end

   assign state  = state_q;
   assign tlr    = (state_q == TLR);
   assign cap_dr = (state_q == CAPDR);
   assign sh_dr  = (state_q == SHDR);
   assign upd_dr = (state_q == UPDR);
   assign cap_ir = (state_q == CAPIR);
   assign sh_ir  = (state_q == SHIR);
   assign upd_ir = (state_q == UPIR);

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised TAP top: IR, instruction decode, DR chains,
// BSR update latch and registered TDO.
module jtag_tap_param
   import jtag_tap_param_pkg::*;
#(
   parameter int          IR_WIDTH     = 4,
   parameter int          BSR_LEN      = 10,
   parameter logic [31:0] IDCODE_VAL   = 32'h1234_5679,
   parameter logic [31:0] USERCODE_VAL = 32'h0000_00A5
) (
   input logic             TCK,
   input logic             TRST,
   jtag_tap_param_if.slave jtag
);

   typedef logic [IR_WIDTH-1:0] ir_t;

   localparam ir_t OP_SAM = ir_t'(OP_SAMPLE);
   localparam ir_t OP_EXT = ir_t'(OP_EXTEST);
   localparam ir_t OP_INT = ir_t'(OP_INTEST);
   localparam ir_t OP_ID  = ir_t'(OP_IDCODE);
   localparam ir_t OP_UC  = ir_t'(OP_USERCODE);
   localparam ir_t OP_BYP = ir_t'(bypass_op(IR_WIDTH));
   localparam ir_t IR_CAP = ir_t'(1);

   if (!idcode_ok(IDCODE_VAL)) begin : g_bad_idcode
      $error("IDCODE_VAL bit 0 must be 1");
   end

   tap_state_e state;
   logic       tlr;
   logic       cap_dr;
   logic       sh_dr;
   logic       upd_dr;
   logic       cap_ir;
   logic       sh_ir;
   logic       upd_ir;

   tap_fsm u_fsm (
      .TCK    (TCK),
      .TRST   (TRST),
      .TMS    (jtag.TMS),
      .state  (state),
      .tlr    (tlr),
      .cap_dr (cap_dr),
      .sh_dr  (sh_dr),
      .upd_dr (upd_dr),
      .cap_ir (cap_ir),
      .sh_ir  (sh_ir),
      .upd_ir (upd_ir)
   );

   ir_t                ir_shift_q, ir_shift_d;
   ir_t                ir_latched_q, ir_latched_d;
   logic [31:0]        id_sr_q, id_sr_d;
   logic [31:0]        uc_sr_q, uc_sr_d;
   logic               byp_q, byp_d;
   logic [BSR_LEN-1:0] bsr_sr_q, bsr_sr_d;
   logic [BSR_LEN-1:0] bsr_upd_q, bsr_upd_d;
   logic               tdo_q, tdo_d;
   logic               tdo_en_q, tdo_en_d;

   dr_sel_e dr_sel;
   logic    sel_id, sel_byp, sel_sam;
   logic    sel_ext, sel_int, sel_uc;

   // Unlisted opcodes fall into BYPASS alongside the all-ones code
   always_comb begin
      dr_sel  = DR_BYPASS;
      sel_id  = 1'b0;
      sel_byp = 1'b0;
      sel_sam = 1'b0;
      sel_ext = 1'b0;
      sel_int = 1'b0;
      sel_uc  = 1'b0;
      unique case (1'b1)
         (ir_latched_q == OP_ID): begin
            sel_id = 1'b1;
            dr_sel = DR_IDCODE;
         end
         (ir_latched_q == OP_UC): begin
            sel_uc = 1'b1;
            dr_sel = DR_USERCODE;
         end
         (ir_latched_q == OP_SAM): begin
            sel_sam = 1'b1;
            dr_sel  = DR_BSR;
         end
         (ir_latched_q == OP_EXT): begin
            sel_ext = 1'b1;
            dr_sel  = DR_BSR;
         end
         (ir_latched_q == OP_INT): begin
            sel_int = 1'b1;
            dr_sel  = DR_BSR;
         end
         (ir_latched_q == OP_BYP): sel_byp = 1'b1;
         default:                  sel_byp = 1'b1;
      endcase
   end

   always_comb begin
      ir_shift_d   = ir_shift_q;
      ir_latched_d = ir_latched_q;
      id_sr_d      = id_sr_q;
      uc_sr_d      = uc_sr_q;
      byp_d        = byp_q;
      bsr_sr_d     = bsr_sr_q;
      bsr_upd_d    = bsr_upd_q;
      tdo_d        = tdo_q;
      tdo_en_d     = sh_dr | sh_ir;

      if (tlr) begin
         ir_latched_d = OP_ID;
         bsr_upd_d    = '0;
      end

      if (cap_ir) ir_shift_d = IR_CAP;
      if (sh_ir) begin
         tdo_d      = ir_shift_q[0];
         ir_shift_d = {jtag.TDI, ir_shift_q[IR_WIDTH-1:1]};
      end
      if (upd_ir) ir_latched_d = ir_shift_q;

      if (cap_dr) begin
         unique case (dr_sel)
            DR_IDCODE:   id_sr_d  = IDCODE_VAL;
            DR_USERCODE: uc_sr_d  = USERCODE_VAL;
            DR_BSR:      bsr_sr_d = jtag.bsr_pin_in;
            default:     byp_d    = 1'b0;
         endcase
      end

      // TDO takes the pre-shift LSB, giving a one-TCK lag per bit
      if (sh_dr) begin
         unique case (dr_sel)
            DR_IDCODE: begin
               tdo_d   = id_sr_q[0];
               id_sr_d = {jtag.TDI, id_sr_q[31:1]};
            end
            DR_USERCODE: begin
               tdo_d   = uc_sr_q[0];
               uc_sr_d = {jtag.TDI, uc_sr_q[31:1]};
            end
            DR_BSR: begin
               tdo_d    = bsr_sr_q[0];
               bsr_sr_d = {jtag.TDI, bsr_sr_q[BSR_LEN-1:1]};
            end
            default: begin
               tdo_d = byp_q;
               byp_d = jtag.TDI;
            end
         endcase
      end

      if (upd_dr && dr_sel == DR_BSR) bsr_upd_d = bsr_sr_q;
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         ir_shift_q   <= '0;
         ir_latched_q <= OP_ID;
         id_sr_q      <= '0;
         uc_sr_q      <= '0;
         byp_q        <= 1'b0;
         bsr_sr_q     <= '0;
         bsr_upd_q    <= '0;
         tdo_q        <= 1'b0;
         tdo_en_q     <= 1'b0;
      end else begin
         ir_shift_q   <= ir_shift_d;
         ir_latched_q <= ir_latched_d;
         id_sr_q      <= id_sr_d;
         uc_sr_q      <= uc_sr_d;
         byp_q        <= byp_d;
         bsr_sr_q     <= bsr_sr_d;
         bsr_upd_q    <= bsr_upd_d;
         tdo_q        <= tdo_d;
         tdo_en_q     <= tdo_en_d;
      end
   end

   assign jtag.TDO          = tdo_q;
   assign jtag.TDO_EN       = tdo_en_q;
   assign jtag.state        = state;
   assign jtag.ir_latched   = ir_latched_q;
   assign jtag.sel_idcode   = sel_id;
   assign jtag.sel_bypass   = sel_byp;
   assign jtag.sel_sample   = sel_sam;
   assign jtag.sel_extest   = sel_ext;
   assign jtag.sel_intest   = sel_int;
   assign jtag.sel_usercode = sel_uc;
   assign jtag.bsr_update   = bsr_upd_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Scoreboard bench for jtag_tap_param: stimulus queues expectations,
// a negedge monitor pops and compares TDO bits and status probes.
module tb_jtag_tap_param;
   import jtag_tap_param_pkg::*;

   localparam int IRW = 4;
   localparam int BL  = 10;

   logic TCK  = 1'b0;
   logic TRST = 1'b1;

   jtag_tap_param_if #(.IR_WIDTH(IRW), .BSR_LEN(BL)) jif ();

   jtag_tap_param #(
      .IR_WIDTH     (IRW),
      .BSR_LEN      (BL),
      .IDCODE_VAL   (32'h1234_5679),
      .USERCODE_VAL (32'h0000_00A5)
   ) dut (
      .TCK  (TCK),
      .TRST (TRST),
      .jtag (jif.slave)
   );

   always #5 TCK = ~TCK;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
   } chk_t;

   chk_t        chk_q[$];
   logic        tdo_exp_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_upd = '0;

   function automatic logic [31:0] probe(input int sig);
      case (sig)
         0: return {28'b0, jif.state};
         1: return 32'(jif.ir_latched);
         2: return {26'b0, jif.sel_idcode, jif.sel_bypass,
                    jif.sel_sample, jif.sel_extest,
                    jif.sel_intest, jif.sel_usercode};
         3: return 32'(jif.bsr_update);
         4: return 32'(jif.TDO);
         5: return 32'(jif.TDO_EN);
         default: return 32'(tdo_exp_q.size());
      endcase
   endfunction

   initial begin
      forever begin
         @(negedge TCK);
         if (jif.TDO_EN === 1'b1) begin
            total++;
            if (tdo_exp_q.size() == 0) begin
               bad++;
               $display("FAIL tdo_extra got=%0b exp=none", jif.TDO);
            end else begin
               logic e;
               e = tdo_exp_q.pop_front();
               if (jif.TDO !== e) begin
                  bad++;
                  $display("FAIL tdo_bit got=%0b exp=%0b", jif.TDO, e);
               end
            end
         end
         while (chk_q.size() > 0) begin
            chk_t        c;
            logic [31:0] g;
            c = chk_q.pop_front();
            g = probe(c.sig);
            total++;
            if (g !== c.exp) begin
               bad++;
               $display("FAIL %s got=%0h exp=%0h", c.name, g, c.exp);
            end
         end
      end
   end

   task automatic push(input string name, input int sig, input logic [31:0] exp);
      chk_q.push_back('{name, sig, exp});
   endtask

   task automatic step(input logic tms, input logic tdi);
      jif.TMS = tms;
      jif.TDI = tdi;
      @(posedge TCK);
      #1;
   endtask

   task automatic shift(input logic [31:0] din, input logic [31:0] dexp,
                        input int n, input bit ex);
      for (int i = 0; i < n; i++) begin
         tdo_exp_q.push_back(dexp[i]);
         step(ex && (i == n - 1), din[i]);
         push("bsr_hold_shift", 3, exp_upd);
      end
   endtask

   task automatic ir_scan(input logic [IRW-1:0] op);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      push("state_shir", 0, 32'hA);
      shift(32'(op), 32'h1, IRW, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      push("ir_latched", 1, 32'(op));
   endtask

   task automatic dr_scan(input logic [31:0] din, input logic [31:0] dexp,
                          input int n, input bit upd);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      push("state_shdr", 0, 32'h2);
      shift(din, dexp, n, 1'b1);
      step(1'b1, 1'b0);
      push("bsr_in_updr", 3, exp_upd);
      step(1'b0, 1'b0);
      if (upd) exp_upd = 32'(din[BL-1:0]);
      push("state_rti", 0, 32'hC);
      push("bsr_after_updr", 3, exp_upd);
   endtask

   task automatic reset_checks();
      push("rst_state", 0, 32'hF);
      push("rst_ir", 1, 32'h7);
      push("rst_tdo", 4, 32'h0);
      push("rst_tdo_en", 5, 32'h0);
      push("rst_bsr", 3, 32'h0);
      push("rst_sel", 2, 32'h20);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      jif.TMS        = 1'b1;
      jif.TDI        = 1'b0;
      jif.bsr_pin_in = '0;
      #12;
      reset_checks();
      @(posedge TCK);
      #1;
      TRST = 1'b0;

      step(1'b0, 1'b0);
      push("state_rti0", 0, 32'hC);
      dr_scan(32'h0, 32'h1234_5679, 32, 1'b0);

      ir_scan(4'hF);
      push("sel_bypass_f", 2, 32'h10);
      dr_scan(32'h0A5, 32'h14A, 9, 1'b0);

      jif.bsr_pin_in = 10'h2AA;
      ir_scan(4'h2);
      push("sel_extest", 2, 32'h04);
      dr_scan(32'h155, 32'h2AA, 10, 1'b1);

      jif.bsr_pin_in = 10'h0F0;
      dr_scan(32'h3C3, 32'h0F0, 10, 1'b1);

      jif.bsr_pin_in = 10'h1E1;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      push("state_ex1dr", 0, 32'h1);
      push("bsr_cap_hold", 3, exp_upd);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      exp_upd = 32'h1E1;
      push("bsr_noshift_upd", 3, exp_upd);

      ir_scan(4'h5);
      push("sel_bypass_5", 2, 32'h10);
      dr_scan(32'h3, 32'h6, 3, 1'b0);

      ir_scan(4'h8);
      push("sel_usercode", 2, 32'h01);
      dr_scan(32'h0, 32'hA5, 32, 1'b0);

      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      push("state_shdr_abort", 0, 32'h2);
      shift(32'h0, 32'hA5, 3, 1'b0);
      @(negedge TCK);
      #1;
      TRST = 1'b1;
      exp_upd = '0;
      reset_checks();
      @(negedge TCK);
      #1;
      TRST = 1'b0;
      jif.TMS = 1'b1;
      @(posedge TCK);
      #1;

      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      push("state_pir", 0, 32'hB);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      push("state_tlr_5tms", 0, 32'hF);
      step(1'b1, 1'b0);
      push("ir_tlr_reload", 1, 32'h7);
      push("sel_tlr", 2, 32'h20);
      push("bsr_tlr", 3, 32'h0);

      step(1'b1, 1'b0);
      push("tdo_drain", 6, 32'h0);
      @(negedge TCK);
      #1;
      @(negedge TCK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
